pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter LOAD_LAT, default 1, range 1..3: bubble cycles inserted per load-use hazard.
REQ-002 Parameter RV32M, default 0: when 1, opcode 0110011 with funct7 0000001 is legal (regwen=1).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 id_valid  in  1  decode stage holds a real instruction.
REQ-006 id_inst  in  32  instruction in decode.
REQ-007 ex_br_taken  in  1  branch or jump resolved taken in EX this cycle.
REQ-008 stall  out  1  hold PC and IF/ID register.
REQ-009 flush  out  1  kill IF/ID contents; equals ex_br_taken.
REQ-010 ex_ctl, mem_ctl, wb_ctl  out  12 each  stage bundle {valid, regwen, asel, bsel, brun, memrw, wbsel[1:0], size[1:0], illegal, isload}.
REQ-011 ex_rd, mem_rd, wb_rd  out  5 each  destination register per stage.
REQ-012 illegal_pulse  out  1  one cycle high when an illegal opcode enters EX.

Function
REQ-013 Decode is combinational on id_inst, registered into EX; EX->MEM->WB shift each cycle, one cycle per stage.
REQ-014 Decode: regwen=1 for opcodes 0110011, 0010011, 0000011, 1101111, 0010111, 0110111, 1100111; 0 otherwise and 0 when rd=x0.
REQ-015 asel=1 for 1100011, 1101111, 0010111; bsel=0 only for 0110011 and 1110011; memrw=1 only for 0100011; brun=1 for 1100011 with funct3 110/111.
REQ-016 wbsel=00 loads, 10 for 1101111/1100111, 01 otherwise; size=funct3[1:0]; isload=1 for 0000011.
REQ-017 illegal=1 for any opcode outside RV32I set {0110011,0010011,0000011,0100011,1100011,1101111,1100111,0010111,0110111,1110011,0001111}, or 0110011/funct7 0000001 when RV32M=0.
REQ-018 Illegal instruction enters EX with valid=1 and regwen=0, memrw=0.
REQ-019 Bubble: ex_ctl all-zero, ex_rd=0.
REQ-020 Hazard: ex_ctl.valid & ex_ctl.isload & ex_rd!=0 & id_valid & ex_rd equals a used source of id_inst (rs1 for all but 0110111/0010111/1101111; rs2 additionally for 0110011/0100011/1100011).
REQ-021 On hazard, load stall counter with LOAD_LAT; stall=1 while counter!=0; counter decrements each cycle; a bubble enters EX every stalled cycle.
REQ-022 While counter!=0, hazard re-detection is suppressed; the held instruction enters EX the cycle after counter reaches 0.
REQ-023 Stall and bubbles are combinational on hazard detection in the first stalled cycle (zero-cycle detect latency).
REQ-024 ex_br_taken=1: bubble into EX next cycle, counter cleared to 0, stall=0 same cycle; flush dominates hazard.
REQ-025 id_valid=0 enters EX as bubble; no hazard raised.
REQ-026 MEM and WB advance during stall; only ID->EX is blocked.
REQ-027 illegal_pulse=ex_ctl.valid & ex_ctl.illegal, asserted once per instruction.

Reset
REQ-028 reset=1 at a rising edge: all stage bundles and rd zero, counter 0, stall 0, illegal_pulse 0, next cycle.
REQ-029 reset mid-stall aborts the stall; the held instruction is discarded.
REQ-030 Outputs are zero while reset held regardless of id_inst.

Verification
REQ-031 lw x5,0(x1) then add x6,x5,x2, LOAD_LAT=1 -> stall=1 one cycle, one bubble in EX, add reaches EX cycle 3, ex_rd=6.
REQ-032 Same sequence, LOAD_LAT=3 -> stall high exactly 3 cycles, three bubbles, MEM/WB drain lw meanwhile.
REQ-033 lw x5 then sw x5,0(x2) -> rs2 hazard detected; lui x5 after lw x5 -> no stall.
REQ-034 Hazard with ex_br_taken=1 same cycle -> stall=0, flush=1, bubble in EX, counter 0.
REQ-035 opcode 1111111 -> illegal_pulse one cycle, ex_ctl regwen=0 memrw=0; mul with RV32M=0 -> illegal, RV32M=1 -> regwen=1.
REQ-036 reset asserted during stall cycle 2 of LOAD_LAT=3 -> all outputs zero next cycle, stall=0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the decode/branch side of the pipeline and pipe_ctrl.
// master drives the decode inputs; slave is the controller.
interface pipe_ctrl_if;
    logic        id_valid;
    logic [31:0] id_inst;
    logic        ex_br_taken;
    logic        stall;
    logic        flush;
    logic [11:0] ex_ctl;
    logic [11:0] mem_ctl;
    logic [11:0] wb_ctl;
    logic [4:0]  ex_rd;
    logic [4:0]  mem_rd;
    logic [4:0]  wb_rd;
    logic        illegal_pulse;

    modport master (
        output id_valid, id_inst, ex_br_taken,
        input  stall, flush, ex_ctl, mem_ctl, wb_ctl, ex_rd, mem_rd, wb_rd, illegal_pulse
    );

    modport slave (
        input  id_valid, id_inst, ex_br_taken,
        output stall, flush, ex_ctl, mem_ctl, wb_ctl, ex_rd, mem_rd, wb_rd, illegal_pulse
    );
endinterface

// File: rtl/pipe_ctrl.sv
// RV32 pipeline controller: decodes ID into a control bundle, shifts it through EX/MEM/WB,
// and inserts load-use bubbles and branch flushes. Bundle: {valid,regwen,asel,bsel,brun,memrw,wbsel,size,illegal,isload}.
module pipe_ctrl #(
    parameter int LOAD_LAT = 1,
    parameter bit RV32M    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    pipe_ctrl_if.slave bus
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;
    localparam logic [6:0] OP_FENCE = 7'b0001111;

    // The detect cycle is itself the first stalled cycle, so the counter holds the remainder.
    localparam logic [1:0] CNT_LOAD = 2'(LOAD_LAT - 1);
    localparam int         VLD  = 11;
    localparam int         ILL  = 1;
    localparam int         ISLD = 0;

    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        illegal;
    logic        regwen;
    logic [1:0]  wbsel;
    logic [11:0] dec_ctl_p0;
    logic [4:0]  dec_rd_p0;

    logic [1:0]  cnt;
    logic [11:0] ex_ctl_p1;
    logic [11:0] mem_ctl_p2;
    logic [11:0] wb_ctl_p3;
    logic [4:0]  ex_rd_p1;
    logic [4:0]  mem_rd_p2;
    logic [4:0]  wb_rd_p3;
    logic        src_hit;
    logic        hazard;
    logic        stall;

    assign op  = bus.id_inst[6:0];
    assign rd  = bus.id_inst[11:7];
    assign f3  = bus.id_inst[14:12];
    assign rs1 = bus.id_inst[19:15];
    assign rs2 = bus.id_inst[24:20];
    assign f7  = bus.id_inst[31:25];

    // ID decode (p0)
    always_comb begin
        illegal = !(op inside {OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_JAL, OP_JALR,
                               OP_AUIPC, OP_LUI, OP_SYS, OP_FENCE})
                  || (op == OP_R && f7 == 7'b0000001 && !RV32M);
        regwen  = !illegal && rd != 5'd0
                  && (op inside {OP_R, OP_I, OP_LOAD, OP_JAL, OP_AUIPC, OP_LUI, OP_JALR});
        wbsel   = (op == OP_LOAD) ? 2'b00 :
                  (op == OP_JAL || op == OP_JALR) ? 2'b10 : 2'b01;
        dec_ctl_p0 = {1'b1, regwen,
                      op inside {OP_B, OP_JAL, OP_AUIPC},
                      !(op inside {OP_R, OP_SYS}),
                      op == OP_B && f3[2:1] == 2'b11,
                      !illegal && op == OP_S,
                      wbsel, f3[1:0], illegal, op == OP_LOAD};
        dec_rd_p0  = regwen ? rd : 5'd0;
    end

    always_comb begin
        src_hit = (!(op inside {OP_LUI, OP_AUIPC, OP_JAL}) && rs1 == ex_rd_p1)
                  || ((op inside {OP_R, OP_S, OP_B}) && rs2 == ex_rd_p1);
        hazard  = !reset && cnt == 2'd0 && bus.id_valid && ex_ctl_p1[VLD]
                  && ex_ctl_p1[ISLD] && ex_rd_p1 != 5'd0 && src_hit;
        stall   = !reset && !bus.ex_br_taken && (hazard || cnt != 2'd0);
    end

    // ID->EX (p1), EX->MEM (p2), MEM->WB (p3); only ID->EX is held by a stall
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= 2'd0;
            ex_ctl_p1  <= '0;
            mem_ctl_p2 <= '0;
            wb_ctl_p3  <= '0;
            ex_rd_p1   <= '0;
            mem_rd_p2  <= '0;
            wb_rd_p3   <= '0;
        end else begin
            mem_ctl_p2 <= ex_ctl_p1;
            mem_rd_p2  <= ex_rd_p1;
            wb_ctl_p3  <= mem_ctl_p2;
            wb_rd_p3   <= mem_rd_p2;
            if (bus.ex_br_taken)
                cnt <= 2'd0;
            else if (hazard)
                cnt <= CNT_LOAD;
            else if (cnt != 2'd0)
                cnt <= cnt - 2'd1;
            if (stall || bus.ex_br_taken || !bus.id_valid) begin
                ex_ctl_p1 <= '0;
                ex_rd_p1  <= '0;
            end else begin
                ex_ctl_p1 <= dec_ctl_p0;
                ex_rd_p1  <= dec_rd_p0;
            end
        end
    end

    assign bus.stall         = stall;
    assign bus.flush         = bus.ex_br_taken;
    assign bus.ex_ctl        = ex_ctl_p1;
    assign bus.mem_ctl       = mem_ctl_p2;
    assign bus.wb_ctl        = wb_ctl_p3;
    assign bus.ex_rd         = ex_rd_p1;
    assign bus.mem_rd        = mem_rd_p2;
    assign bus.wb_rd         = wb_rd_p3;
    assign bus.illegal_pulse = ex_ctl_p1[VLD] & ex_ctl_p1[ILL];
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (LOAD_LAT=1/RV32M=0 and LOAD_LAT=3/RV32M=1) share one
// stimulus stream; a per-cycle reference model plus directed literal checks.
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_inst;
    logic        br;
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          armed   = 1'b0;

    localparam logic [31:0] LW  = 32'h0000A283;  // lw  x5,0(x1)
    localparam logic [31:0] ADD = 32'h00228333;  // add x6,x5,x2
    localparam logic [31:0] SW  = 32'h00512023;  // sw  x5,0(x2)
    localparam logic [31:0] LUI = 32'h000282B7;  // lui x5,0x28 (rs1 field happens to be 5)
    localparam logic [31:0] ILI = 32'h0000007F;  // opcode 1111111
    localparam logic [31:0] MUL = 32'h022083B3;  // mul x7,x1,x2

    always #5 clk = ~clk;

    pipe_ctrl_if b1 ();
    pipe_ctrl_if b3 ();

    assign b1.id_valid    = id_valid;
    assign b1.id_inst     = id_inst;
    assign b1.ex_br_taken = br;
    assign b3.id_valid    = id_valid;
    assign b3.id_inst     = id_inst;
    assign b3.ex_br_taken = br;

    pipe_ctrl #(.LOAD_LAT(1), .RV32M(1'b0)) u1 (.clk(clk), .reset(reset), .bus(b1));
    pipe_ctrl #(.LOAD_LAT(3), .RV32M(1'b1)) u3 (.clk(clk), .reset(reset), .bus(b3));

    logic [53:0] got [2];
    assign got[0] = {b1.stall, b1.flush, b1.ex_ctl, b1.mem_ctl, b1.wb_ctl,
                     b1.ex_rd, b1.mem_rd, b1.wb_rd, b1.illegal_pulse};
    assign got[1] = {b3.stall, b3.flush, b3.ex_ctl, b3.mem_ctl, b3.wb_ctl,
                     b3.ex_rd, b3.mem_rd, b3.wb_rd, b3.illegal_pulse};

    // Reference model: stage contents as arrays indexed [instance][0=EX,1=MEM,2=WB]
    logic [11:0] m_ctl [2][3];
    logic [4:0]  m_rd  [2][3];
    int          m_rem [2];

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [16:0] mdec(logic [31:0] i, bit m);
        logic [6:0] op;
        bit ill, wr;
        logic [1:0] wb;
        op  = i[6:0];
        ill = !(op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0010111, 7'b0110111, 7'b1110011,
                           7'b0001111})
              || (op == 7'b0110011 && i[31:25] == 7'b0000001 && !m);
        wr  = !ill && i[11:7] != 5'd0
              && (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
                             7'b0010111, 7'b0110111, 7'b1100111});
        if (op == 7'b0000011) wb = 2'b00;
        else if (op == 7'b1101111 || op == 7'b1100111) wb = 2'b10;
        else wb = 2'b01;
        return {1'b1, wr, op inside {7'b1100011, 7'b1101111, 7'b0010111},
                !(op inside {7'b0110011, 7'b1110011}),
                op == 7'b1100011 && i[14:13] == 2'b11,
                op == 7'b0100011 && !ill, wb, i[13:12], ill, op == 7'b0000011,
                wr ? i[11:7] : 5'd0};
    endfunction

    function automatic bit uses_reg(logic [31:0] i, logic [4:0] r);
        logic [6:0] op;
        op = i[6:0];
        return (!(op inside {7'b0110111, 7'b0010111, 7'b1101111}) && i[19:15] == r)
            || ((op inside {7'b0110011, 7'b0100011, 7'b1100011}) && i[24:20] == r);
    endfunction

    function automatic bit m_hz(int k);
        return m_rem[k] == 0 && m_ctl[k][0][11] && m_ctl[k][0][0] && m_rd[k][0] != 5'd0
            && id_valid && uses_reg(id_inst, m_rd[k][0]);
    endfunction

    function automatic bit m_stall(int k);
        return !reset && !br && (m_rem[k] > 0 || m_hz(k));
    endfunction

    function automatic logic [53:0] m_exp(int k);
        return {m_stall(k), br, m_ctl[k][0], m_ctl[k][1], m_ctl[k][2],
                m_rd[k][0], m_rd[k][1], m_rd[k][2], m_ctl[k][0][11] & m_ctl[k][0][1]};
    endfunction

    // Compare on the falling edge, then advance the model to what the next rising edge produces.
    initial begin
        bit st, hz;
        logic [53:0] e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (armed) begin
                    e = m_exp(k);
                    n_tests++;
                    if (got[k] !== e) begin
                        n_fail++;
                        $display("FAIL model_cmp_u%0d at %0t: got %h required %h", k, $time, got[k], e);
                    end
                end
                st = m_stall(k);
                hz = m_hz(k);
                if (reset) begin
                    for (int s = 0; s < 3; s++) begin
                        m_ctl[k][s] = '0;
                        m_rd[k][s]  = '0;
                    end
                    m_rem[k] = 0;
                end else begin
                    m_ctl[k][2] = m_ctl[k][1];
                    m_rd[k][2]  = m_rd[k][1];
                    m_ctl[k][1] = m_ctl[k][0];
                    m_rd[k][1]  = m_rd[k][0];
                    if (br) begin
                        m_ctl[k][0] = '0;
                        m_rd[k][0]  = '0;
                        m_rem[k]    = 0;
                    end else if (st) begin
                        m_ctl[k][0] = '0;
                        m_rd[k][0]  = '0;
                        m_rem[k]    = hz ? lat_of(k) - 1 : m_rem[k] - 1;
                    end else if (!id_valid) begin
                        m_ctl[k][0] = '0;
                        m_rd[k][0]  = '0;
                    end else begin
                        {m_ctl[k][0], m_rd[k][0]} = mdec(id_inst, k == 1);
                    end
                end
            end
        end
    end

    task automatic chk(string nm, logic [31:0] g, logic [31:0] e);
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, g, e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [31:0] i, logic b);
        id_valid = v;
        id_inst  = i;
        br       = b;
        #1;
    endtask

    task automatic idle(int n);
        drive(1'b0, 32'd0, 1'b0);
        repeat (n) cyc();
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [31:0] i;
        logic [6:0]  op;
        i = $urandom;
        case ($urandom_range(0, 13))
            0: op = 7'b0110011;  1: op = 7'b0010011;  2: op = 7'b0000011;
            3: op = 7'b0000011;  4: op = 7'b0100011;  5: op = 7'b1100011;
            6: op = 7'b1101111;  7: op = 7'b1100111;  8: op = 7'b0010111;
            9: op = 7'b0110111;  10: op = 7'b1110011; 11: op = 7'b0001111;
            12: op = 7'b1111111; default: op = 7'b0000000;
        endcase
        i[6:0]   = op;
        i[11:7]  = 5'($urandom_range(0, 7));
        i[19:15] = 5'($urandom_range(0, 7));
        i[24:20] = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) i[31:25] = 7'b0000001;
        return i;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 3; s++) begin
                m_ctl[k][s] = '0;
                m_rd[k][s]  = '0;
            end
            m_rem[k] = 0;
        end
        reset = 1'b1;
        drive(1'b1, ADD, 1'b0);
        cyc();
        armed = 1'b1;
        cyc();
        chk("reset_ex_ctl", 32'(b1.ex_ctl), 32'd0);
        chk("reset_stall", 32'(b3.stall), 32'd0);
        reset = 1'b0;
        idle(2);

        // lw x5 then add x6,x5,x2
        drive(1'b1, LW, 1'b0);
        cyc();
        drive(1'b1, ADD, 1'b0);
        chk("lu_ex_lw", 32'(b1.ex_ctl), 32'hD09);
        chk("lu_stall_l1", 32'(b1.stall), 32'd1);
        chk("lu_stall_l3_c1", 32'(b3.stall), 32'd1);
        cyc();
        chk("lu_bubble_l1", 32'(b1.ex_ctl), 32'd0);
        chk("lu_unstall_l1", 32'(b1.stall), 32'd0);
        chk("lu_stall_l3_c2", 32'(b3.stall), 32'd1);
        chk("lu_mem_lw_l3", 32'(b3.mem_ctl), 32'hD09);
        cyc();
        chk("lu_add_ex_l1", 32'(b1.ex_ctl), 32'hC10);
        chk("lu_add_rd_l1", 32'(b1.ex_rd), 32'd6);
        chk("lu_stall_l3_c3", 32'(b3.stall), 32'd1);
        chk("lu_wb_lw_l3", 32'(b3.wb_ctl), 32'hD09);
        cyc();
        chk("lu_unstall_l3", 32'(b3.stall), 32'd0);
        chk("lu_bubble3_l3", 32'(b3.ex_ctl), 32'd0);
        cyc();
        chk("lu_add_rd_l3", 32'(b3.ex_rd), 32'd6);
        idle(4);

        // rs2 hazard on sw, none on lui
        drive(1'b1, LW, 1'b0);
        cyc();
        drive(1'b1, SW, 1'b0);
        chk("sw_rs2_hazard", 32'(b1.stall), 32'd1);
        idle(5);
        drive(1'b1, LW, 1'b0);
        cyc();
        drive(1'b1, LUI, 1'b0);
        chk("lui_no_stall_l1", 32'(b1.stall), 32'd0);
        chk("lui_no_stall_l3", 32'(b3.stall), 32'd0);
        idle(4);

        // hazard coinciding with a taken branch
        drive(1'b1, LW, 1'b0);
        cyc();
        drive(1'b1, ADD, 1'b1);
        chk("br_stall", 32'(b3.stall), 32'd0);
        chk("br_flush", 32'(b3.flush), 32'd1);
        cyc();
        drive(1'b0, 32'd0, 1'b0);
        chk("br_bubble", 32'(b3.ex_ctl), 32'd0);
        chk("br_cnt_clear", 32'(b3.stall), 32'd0);
        idle(2);

        // illegal opcode and mul
        drive(1'b1, ILI, 1'b0);
        cyc();
        drive(1'b0, 32'd0, 1'b0);
        chk("ill_pulse", 32'(b1.illegal_pulse), 32'd1);
        chk("ill_ctl", 32'(b1.ex_ctl), 32'h912);
        cyc();
        chk("ill_pulse_once", 32'(b1.illegal_pulse), 32'd0);
        drive(1'b1, MUL, 1'b0);
        cyc();
        drive(1'b0, 32'd0, 1'b0);
        chk("mul_ill_ctl", 32'(b1.ex_ctl), 32'h812);
        chk("mul_ill_pulse", 32'(b1.illegal_pulse), 32'd1);
        chk("mul_m_ctl", 32'(b3.ex_ctl), 32'hC10);
        chk("mul_m_rd", 32'(b3.ex_rd), 32'd7);
        idle(3);

        // reset in the second stalled cycle of LOAD_LAT=3
        drive(1'b1, LW, 1'b0);
        cyc();
        drive(1'b1, ADD, 1'b0);
        cyc();
        chk("rst_mid_pre", 32'(b3.stall), 32'd1);
        reset = 1'b1;
        cyc();
        chk("rst_mid_stall", 32'(b3.stall), 32'd0);
        chk("rst_mid_ex", 32'(b3.ex_ctl), 32'd0);
        chk("rst_mid_mem", 32'(b3.mem_ctl), 32'd0);
        chk("rst_mid_wb", 32'(b3.wb_ctl), 32'd0);
        reset = 1'b0;
        idle(4);

        // randomized traffic, model-checked every cycle
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive(1'($urandom_range(0, 4) != 0), rnd_inst(), 1'($urandom_range(0, 9) == 0));
            cyc();
        end
        reset = 1'b0;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
